// File: rtl/approxmul_pkg.sv
// Shared types and constants for the iterative approximate multiplier.
// Holds the controller state enum and the digit/tile width constants.
package approxmul_pkg;

  localparam int DIGIT_W = 2;
  localparam int TILE_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } approxmul_state_t;

endpackage

// File: rtl/approxmul_tile.sv
// 2-bit x 2-bit multiplier tile, approximate by default (3x3 -> 7).
// Ports: a, b digits in; p 4-bit product out. Macro: APPROXMUL_EXACT_EN.
module approxmul_tile
  import approxmul_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic [TILE_W-1:0]  p
);

`ifdef APPROXMUL_EXACT_EN
  logic cross;

  // Carry out of the middle column
  assign cross = a[1] & b[0] & a[0] & b[1];
  assign p[0]  = a[0] & b[0];
  assign p[1]  = (a[1] & b[0]) ^ (a[0] & b[1]);
  assign p[2]  = (a[1] & b[1]) ^ cross;
  assign p[3]  = (a[1] & b[1]) & cross;
`else
  // OR replaces XOR and the carry is dropped
  assign p[0] = a[0] & b[0];
  assign p[1] = (a[1] & b[0]) | (a[0] & b[1]);
  assign p[2] = a[1] & b[1];
  assign p[3] = 1'b0;
`endif

endmodule

// File: rtl/approxmul_seq.sv
// Iterative WIDTH x WIDTH multiplier, one b-digit row per cycle.
// Ports: clk, resetn, in_valid/in_ready/in_a/in_b,
// out_valid/out_ready/out_prod, busy. Macro: APPROXMUL_EXACT_EN.
module approxmul_seq
  import approxmul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               busy
);

  localparam int N  = WIDTH / DIGIT_W;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;

  approxmul_state_t state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [PW-1:0]      acc;
  logic [KW-1:0]      k;

  logic [KW:0]        shamt;
  logic [DIGIT_W-1:0] b_dig;
  logic [TILE_W-1:0]  tile_p [N];
  logic [PW-1:0]      row;
  logic [PW-1:0]      addend;

  // Digit index k maps to a bit shift of 2k
  assign shamt = {k, 1'b0};
  assign b_dig = DIGIT_W'(b_q >> shamt);

  for (genvar g = 0; g < N; g++) begin : g_tile
    approxmul_tile u_tile (
      .a (a_q[DIGIT_W*g +: DIGIT_W]),
      .b (b_dig),
      .p (tile_p[g])
    );
  end

  always_comb begin
    row = '0;
    for (int i = 0; i < N; i++) begin
      row = row + (PW'(tile_p[i]) << (DIGIT_W * i));
    end
  end

  assign addend = row << shamt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      k     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            acc   <= '0;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc + addend;
          if (k == KW'(N - 1)) begin
            k     <= '0;
            state <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign out_prod  = acc;

endmodule

// File: tb/tb_approxmul_seq.sv
// Self-checking bench for approxmul_seq at WIDTH = 32.
// Scoreboard queue of expected products, one task per scenario.
module tb_approxmul_seq;

  localparam int W = 32;
  localparam int N = 16;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic           in_ready;
  logic           out_valid;
  logic           busy;
  logic [2*W-1:0] out_prod;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  approxmul_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] s;
    logic [63:0] p;
    logic [31:0] da;
    logic [31:0] db;
    s = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        da = (a >> (2 * i)) & 32'd3;
        db = (b >> (2 * j)) & 32'd3;
        p = 64'(da * db);
`ifndef APPROXMUL_EXACT_EN
        if (p == 64'd9) p = 64'd7;
`endif
        s = s + (p << (2 * (i + j)));
      end
    end
    return s;
  endfunction

  task automatic accept_op(input logic [31:0] a, input logic [31:0] b);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic take_output();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_prod !== '0) begin
      errors++;
      $display("FAIL reset_hold rdy/vld/busy=%b prod=%h want 100/0",
               {in_ready, out_valid, busy}, out_prod);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_prod !== '0) begin
      errors++;
      $display("FAIL reset_release rdy/vld/busy=%b prod=%h want 100/0",
               {in_ready, out_valid, busy}, out_prod);
    end
  endtask

  task automatic test_known();
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic [63:0] te [4];
    logic [63:0] e;
    int cyc;
    ta[0] = 32'h33; tb[0] = 32'h3;
    ta[1] = 32'h5;  tb[1] = 32'h3;  te[1] = 64'hF;
    ta[2] = 32'hF;  tb[2] = 32'hF;
    ta[3] = 32'h0;  tb[3] = 32'hFFFF_FFFF; te[3] = 64'h0;
`ifdef APPROXMUL_EXACT_EN
    te[0] = 64'h99;
    te[2] = 64'hE1;
`else
    te[0] = 64'h77;
    te[2] = 64'hAF;
`endif
    for (int t = 0; t < 4; t++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL known_ready[%0d] got %b want 1", t, in_ready);
      end
      exp_q.push_back(te[t]);
      accept_op(ta[t], tb[t]);
      wait_valid(cyc);
      checks++;
      if (cyc !== N) begin
        errors++;
        $display("FAIL known_latency[%0d] got %0d want %0d", t, cyc, N);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL known_busy[%0d] got %b want 1", t, busy);
      end
      e = exp_q.pop_front();
      checks++;
      if (out_prod !== e) begin
        errors++;
        $display("FAIL known_prod[%0d] got %h want %h", t, out_prod, e);
      end
      take_output();
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
        errors++;
        $display("FAIL known_idle[%0d] rdy/vld/busy=%b want 100",
                 t, {in_ready, out_valid, busy});
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] e;
    int cyc;
    for (int t = 0; t < 6; t++) begin
      a = $urandom;
      b = $urandom;
      if (t == 0) begin
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
      end
      exp_q.push_back(model(a, b));
      accept_op(a, b);
      wait_valid(cyc);
      e = exp_q.pop_front();
      checks++;
      if (cyc !== N || out_prod !== e) begin
        errors++;
        $display("FAIL random_prod[%0d] a=%h b=%h got %h lat=%0d want %h",
                 t, a, b, out_prod, cyc, e);
      end
      take_output();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] e;
    int cyc;
    a = 32'hDEAD_BEEF;
    b = 32'hF0F0_3C3C;
    exp_q.push_back(model(a, b));
    accept_op(a, b);
    wait_valid(cyc);
    in_valid = 1'b1;
    in_a = 32'h1234_5678;
    in_b = 32'h9ABC_DEF0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_prod !== exp_q[0]) begin
        errors++;
        $display("FAIL bp_hold[%0d] vld=%b rdy=%b prod=%h want 1/0/%h",
                 c, out_valid, in_ready, out_prod, exp_q[0]);
      end
      @(posedge clk);
      #1;
      in_a = $urandom;
    end
    in_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (out_prod !== e) begin
      errors++;
      $display("FAIL bp_prod got %h want %h", out_prod, e);
    end
    take_output();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL bp_no_accept rdy/vld/busy=%b want 100",
               {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] e;
    int cyc;
    accept_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_prod !== '0) begin
      errors++;
      $display("FAIL midrun_reset rdy/vld/busy=%b prod=%h want 100/0",
               {in_ready, out_valid, busy}, out_prod);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 32'h0000_3333;
    b = 32'hC000_0007;
    exp_q.push_back(model(a, b));
    resetn = 1'b1;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(cyc);
    checks++;
    if (cyc !== N) begin
      errors++;
      $display("FAIL midrun_first_accept lat=%0d want %0d", cyc, N);
    end
    e = exp_q.pop_front();
    checks++;
    if (out_prod !== e) begin
      errors++;
      $display("FAIL midrun_prod got %h want %h", out_prod, e);
    end
    take_output();
  endtask

  task automatic test_back_to_back();
    int nacc;
    int nout;
    int last_acc;
    int cyc;
    logic [63:0] e;
    nacc = 0;
    nout = 0;
    last_acc = 0;
    cyc = 0;
    in_a = $urandom;
    in_b = $urandom;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (nout < 4 && cyc < 200) begin
      if (in_ready === 1'b1) begin
        exp_q.push_back(model(in_a, in_b));
        if (nacc > 0) begin
          checks++;
          if (cyc - last_acc !== N + 2) begin
            errors++;
            $display("FAIL b2b_spacing got %0d want %0d",
                     cyc - last_acc, N + 2);
          end
        end
        last_acc = cyc;
        nacc++;
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected got %h want none", out_prod);
        end else begin
          e = exp_q.pop_front();
          if (out_prod !== e) begin
            errors++;
            $display("FAIL b2b_prod[%0d] got %h want %h", nout, out_prod, e);
          end
        end
        nout++;
      end
      if (nout == 4) in_valid = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      in_a = $urandom;
      in_b = $urandom;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (nout !== 4 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL b2b_count outputs=%0d left=%0d want 4/0",
               nout, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
